// File: rtl/ro_100_pkg.sv
// Shared definitions for the RO_100 AXI4-Lite slave: register map, STATUS
// layout, measurement FSM states and AXI response codes.
package ro_100_pkg;

  localparam logic [2:0] CTRL_IDX    = 3'd0;
  localparam logic [2:0] WINDOW_IDX  = 3'd1;
  localparam logic [2:0] SELECT_IDX  = 3'd2;
  localparam logic [2:0] SCRATCH_IDX = 3'd3;
  localparam logic [2:0] COUNT_IDX   = 3'd4;
  localparam logic [2:0] STATUS_IDX  = 3'd5;
  localparam logic [2:0] ID_IDX      = 3'd6;
  localparam logic [2:0] CLEAR_IDX   = 3'd7;

  localparam logic [31:0] ID_VALUE = 32'h524F_0064;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_OVERRUN_BIT = 2;
  localparam int STAT_BADSEL_BIT  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } meas_state_t;

  // SLVERR is reserved; every transfer currently completes OKAY.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ro_100_edge_counter.sv
// Gated edge counter: synchronizes the selected ring oscillator, detects its
// rising edges and counts them over a window of bus clocks.
module ro_100_edge_counter
  import ro_100_pkg::*;
#(
  parameter int C_NUM_RO = 100,
  parameter int SEL_W    = 7,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    window_i,
  input  logic [SEL_W-1:0]    sel_i,
  input  logic [C_NUM_RO-1:0] ro_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    count_o
);

  meas_state_t      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [SEL_W-1:0] mux_sel;
  logic             ro_mux;
  logic             rise;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // While idle the mux follows the live selection so the synchronizer has
  // already settled on the chosen oscillator when a measurement starts.
  assign mux_sel = (state_q == IDLE) ? sel_i : sel_q;

  always_comb begin
    ro_mux = 1'b0;
    for (int i = 0; i < C_NUM_RO; i++) begin
      if (mux_sel == SEL_W'(i)) ro_mux = ro_i[i];
    end
  end

  assign rise = sync2_q & ~prev_q;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    gate_d   = gate_q;
    edge_d   = edge_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          sel_d   = sel_i;
          gate_d  = window_i;
          edge_d  = '0;
        end
      end
      RUN: begin
        if (gate_q == '0) begin
          state_d = DONE;
        end else begin
          gate_d = gate_q - CNT_W'(1);
          if (rise) edge_d = sat_inc(edge_q);
        end
      end
      DONE: begin
        state_d  = IDLE;
        result_d = edge_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      gate_q   <= '0;
      edge_q   <= '0;
      result_q <= '0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      gate_q   <= gate_d;
      edge_q   <= edge_d;
      result_q <= result_d;
      sync1_q  <= ro_mux;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign count_o = result_q;

endmodule

// File: rtl/ro_100_axil_slave.sv
// AXI4-Lite register front end for the RO_100 frequency-measurement engine:
// four RW config registers, read-only results, sticky status and a clear port.
module ro_100_axil_slave
  import ro_100_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_NUM_RO           = 100
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  input  logic [C_NUM_RO-1:0]               ro_in,
  output logic                              meas_done
);

  localparam logic [6:0] RO_LIMIT = 7'(C_NUM_RO);

  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] window_q, window_d;
  logic [31:0] select_q, select_d;
  logic [31:0] scratch_q, scratch_d;
  logic        done_st_q, done_st_d;
  logic        ovr_st_q, ovr_st_d;
  logic        bad_st_q, bad_st_d;

  logic        wr_fire, rd_fire, start_req, sel_bad;
  logic [2:0]  wr_idx, rd_idx;
  logic [6:0]  sel_eff;
  logic [31:0] status_w, rd_mux;
  logic        eng_busy, eng_done;
  logic [31:0] eng_count;
  logic        unused_ok;

  function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  st);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) begin
      if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign wr_idx    = s00_axi_awaddr[4:2];
  assign rd_idx    = s00_axi_araddr[4:2];
  assign wr_fire   = wready_q & s00_axi_awvalid & s00_axi_wvalid;
  assign rd_fire   = arready_q & s00_axi_arvalid;
  assign start_req = wr_fire && (wr_idx == CTRL_IDX) &&
                     s00_axi_wstrb[0] && s00_axi_wdata[0];

  // Out-of-range selections fall back to oscillator 0 and are flagged.
  assign sel_bad = (select_q[6:0] >= RO_LIMIT);
  assign sel_eff = sel_bad ? 7'd0 : select_q[6:0];

  ro_100_edge_counter #(
    .C_NUM_RO (C_NUM_RO),
    .SEL_W    (7),
    .CNT_W    (32)
  ) u_edge_counter (
    .clk      (s00_axi_aclk),
    .rst      (s00_axi_areset),
    .start_i  (start_req),
    .window_i (window_q),
    .sel_i    (sel_eff),
    .ro_i     (ro_in),
    .busy_o   (eng_busy),
    .done_o   (eng_done),
    .count_o  (eng_count)
  );

  always_comb begin
    status_w                   = '0;
    status_w[STAT_BUSY_BIT]    = eng_busy;
    status_w[STAT_DONE_BIT]    = done_st_q;
    status_w[STAT_OVERRUN_BIT] = ovr_st_q;
    status_w[STAT_BADSEL_BIT]  = bad_st_q;
    case (rd_idx)
      CTRL_IDX:    rd_mux = ctrl_q;
      WINDOW_IDX:  rd_mux = window_q;
      SELECT_IDX:  rd_mux = select_q;
      SCRATCH_IDX: rd_mux = scratch_q;
      COUNT_IDX:   rd_mux = eng_count;
      STATUS_IDX:  rd_mux = status_w;
      ID_IDX:      rd_mux = ID_VALUE;
      default:     rd_mux = '0;
    endcase
  end

  // Handshake: ready pulses for one cycle and is blocked while a response is
  // pending, so at most one transfer per channel is outstanding.
  always_comb begin
    wready_d  = ~wready_q & s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q;
    arready_d = ~arready_q & s00_axi_arvalid & ~rvalid_q;
    bvalid_d  = bvalid_q;
    if (wr_fire)                          bvalid_d = 1'b1;
    else if (bvalid_q && s00_axi_bready)  bvalid_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    window_d  = window_q;
    select_d  = select_q;
    scratch_d = scratch_q;
    done_st_d = done_st_q;
    ovr_st_d  = ovr_st_q;
    bad_st_d  = bad_st_q;
    if (wr_fire) begin
      case (wr_idx)
        CTRL_IDX:    ctrl_d    = apply_strb(ctrl_q, s00_axi_wdata, s00_axi_wstrb);
        WINDOW_IDX:  window_d  = apply_strb(window_q, s00_axi_wdata, s00_axi_wstrb);
        SELECT_IDX:  select_d  = apply_strb(select_q, s00_axi_wdata, s00_axi_wstrb);
        SCRATCH_IDX: scratch_d = apply_strb(scratch_q, s00_axi_wdata, s00_axi_wstrb);
        CLEAR_IDX: begin
          done_st_d = 1'b0;
          ovr_st_d  = 1'b0;
          bad_st_d  = 1'b0;
        end
        default: ;
      endcase
    end
    // New events win over a clear landing on the same edge.
    if (eng_done)                          done_st_d = 1'b1;
    if (start_req && eng_busy)             ovr_st_d  = 1'b1;
    if (start_req && !eng_busy && sel_bad) bad_st_d  = 1'b1;
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      window_q  <= '0;
      select_q  <= '0;
      scratch_q <= '0;
      done_st_q <= 1'b0;
      ovr_st_q  <= 1'b0;
      bad_st_q  <= 1'b0;
    end else begin
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      window_q  <= window_d;
      select_q  <= select_d;
      scratch_q <= scratch_d;
      done_st_q <= done_st_d;
      ovr_st_q  <= ovr_st_d;
      bad_st_q  <= bad_st_d;
    end
  end

  assign s00_axi_awready = wready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = RESP_OKAY;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = RESP_OKAY;
  assign meas_done       = eng_done;

endmodule

// File: tb/tb_ro_100_axil_slave.sv
// Bench for ro_100_axil_slave: table-driven register vectors, a read
// scoreboard and hand-written measurement / handshake / reset sequences.
module tb_ro_100_axil_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [99:0] ro_in;
  logic        meas_done;

  int total = 0;
  int bad   = 0;
  int done_pulses = 0;
  int aw_hs = 0;
  int ar_hs = 0;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    string       name;
  } rexp_t;
  rexp_t sbq[$];

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vt[8];

  always #5 clk = ~clk;

  ro_100_axil_slave dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (rst),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .ro_in           (ro_in),
    .meas_done       (meas_done)
  );

  // All oscillators toggle every 10 clocks: one rising edge per 20 clocks.
  initial begin
    ro_in = '0;
    forever begin
      repeat (10) @(negedge clk);
      ro_in = ~ro_in;
    end
  end

  always @(negedge clk) begin
    if (meas_done) done_pulses++;
    if (awready && awvalid && wvalid) aw_hs++;
    if (arready && arvalid) ar_hs++;
  end

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp, input logic [31:0] mask);
    total++;
    if ((act & mask) !== (exp & mask)) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (mask 0x%08h)", nm, act, exp, mask);
    end
  endfunction

  function automatic void range_chk(input string nm, input logic [31:0] v,
                                    input int lo, input int hi);
    total++;
    if (int'(v) < lo || int'(v) > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, v, lo, hi);
    end
  endfunction

  function automatic void sb_pop_check(input logic [31:0] d, input logic [1:0] resp);
    rexp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL rd_unexpected: got 0x%08h expected no read data", d);
    end else begin
      e = sbq.pop_front();
      check(e.name, d, e.exp, e.mask);
      check({e.name, "_rresp"}, {30'b0, resp}, 32'h0, 32'hFFFF_FFFF);
    end
  endfunction

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL wr_accept: no awready/wready for addr 0x%02h within 50 cycles", a);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bvalid) begin
      total++; bad++;
      $display("FAIL wr_bvalid: no bvalid for addr 0x%02h within 50 cycles", a);
      return;
    end
    check("bresp", {30'b0, bresp}, 32'h0, 32'hFFFF_FFFF);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] e, input logic [31:0] m,
                          input string nm, output logic [31:0] d);
    int    n;
    rexp_t r;
    r.exp = e; r.mask = m; r.name = nm;
    sbq.push_back(r);
    d = '0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!arready) begin
      total++; bad++;
      $display("FAIL %s: no arready within 50 cycles", nm);
      arvalid = 1'b0;
      void'(sbq.pop_back());
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rvalid) begin
      total++; bad++;
      $display("FAIL %s: no rvalid within 50 cycles", nm);
      void'(sbq.pop_back());
      return;
    end
    d = rdata;
    sb_pop_check(rdata, rresp);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int base, input int lim, input string nm);
    int n;
    n = 0;
    while (done_pulses <= base && n < lim) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done_pulses <= base) begin
      bad++;
      $display("FAIL %s: meas_done not seen within %0d cycles", nm, lim);
    end
  endtask

  initial begin
    logic [31:0] d, cap_r;
    logic [1:0]  cap_b;
    logic        stable;
    int          base, aw0, ar0, n;

    vt[0] = '{5'h00, 32'h0000_0001, 4'hF, 32'h0000_0001, "rb_ctrl"};
    vt[1] = '{5'h04, 32'h0000_0002, 4'hF, 32'h0000_0002, "rb_window"};
    vt[2] = '{5'h08, 32'h0000_0003, 4'hF, 32'h0000_0003, "rb_select"};
    vt[3] = '{5'h0C, 32'h0000_0004, 4'hF, 32'h0000_0004, "rb_scratch"};
    vt[4] = '{5'h10, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, "rb_count_ro"};
    vt[5] = '{5'h18, 32'h1234_5678, 4'hF, 32'h524F_0064, "rb_id"};
    vt[6] = '{5'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, "rb_clear"};
    vt[7] = '{5'h14, 32'h0000_000F, 4'hF, 32'h0000_0000, "rb_status"};

    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {24'b0, awready, wready, bvalid, arready, rvalid, meas_done, bresp | rresp},
          32'h0, 32'hFFFF_FFFF);
    check("reset_rdata", rdata, 32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b0;

    // Register file: write every vector, then read every vector back.
    for (int i = 0; i < 8; i++) axi_write(vt[i].addr, vt[i].wd, vt[i].strb);
    for (int i = 0; i < 8; i++) axi_read(vt[i].addr, vt[i].exp, 32'hFFFF_FFFF, vt[i].name, d);

    // Byte strobes on SCRATCH.
    axi_write(5'h0C, 32'h0000_0000, 4'hF);
    axi_write(5'h0C, 32'hAABB_CCDD, 4'b0010);
    axi_read(5'h0C, 32'h0000_CC00, 32'hFFFF_FFFF, "strb_0010", d);
    axi_write(5'h0C, 32'h1122_3344, 4'b1001);
    axi_read(5'h0C, 32'h1100_CC44, 32'hFFFF_FFFF, "strb_1001", d);

    // Measurement: WINDOW=100 on RO 5; CTRL=0 mid-run must not abort.
    axi_write(5'h1C, 32'h0, 4'hF);
    axi_write(5'h04, 32'd100, 4'hF);
    axi_write(5'h08, 32'd5, 4'hF);
    base = done_pulses;
    axi_write(5'h00, 32'h1, 4'hF);
    axi_read(5'h14, 32'h1, 32'h1, "busy_after_start", d);
    axi_write(5'h00, 32'h0, 4'hF);
    wait_done(base, 400, "meas1_done");
    repeat (5) @(negedge clk);
    check("meas1_pulse_once", 32'(done_pulses - base), 32'd1, 32'hFFFF_FFFF);
    axi_read(5'h10, 32'h0, 32'h0, "meas1_count_raw", d);
    range_chk("meas1_count", d, 4, 6);
    axi_read(5'h14, 32'h2, 32'hFFFF_FFFF, "meas1_status", d);

    // Start while busy sets overrun and leaves the running measurement alone.
    axi_write(5'h1C, 32'h0, 4'hF);
    base = done_pulses;
    axi_write(5'h00, 32'h1, 4'hF);
    axi_write(5'h00, 32'h1, 4'hF);
    wait_done(base, 400, "meas2_done");
    repeat (5) @(negedge clk);
    check("meas2_pulse_once", 32'(done_pulses - base), 32'd1, 32'hFFFF_FFFF);
    axi_read(5'h10, 32'h0, 32'h0, "meas2_count_raw", d);
    range_chk("meas2_count", d, 4, 6);
    axi_read(5'h14, 32'h6, 32'hFFFF_FFFF, "overrun_status", d);
    axi_write(5'h1C, 32'h0, 4'hF);
    axi_read(5'h14, 32'h0, 32'hFFFF_FFFF, "cleared_status", d);

    // Zero-length window.
    axi_write(5'h04, 32'd0, 4'hF);
    base = done_pulses;
    axi_write(5'h00, 32'h1, 4'hF);
    wait_done(base, 50, "win0_done");
    repeat (3) @(negedge clk);
    axi_read(5'h10, 32'h0, 32'hFFFF_FFFF, "win0_count", d);
    axi_read(5'h14, 32'h2, 32'hFFFF_FFFF, "win0_status", d);

    // Out-of-range select falls back to RO 0.
    axi_write(5'h1C, 32'h0, 4'hF);
    axi_write(5'h04, 32'd100, 4'hF);
    axi_write(5'h08, 32'd120, 4'hF);
    base = done_pulses;
    axi_write(5'h00, 32'h1, 4'hF);
    wait_done(base, 400, "badsel_done");
    repeat (5) @(negedge clk);
    axi_read(5'h14, 32'hA, 32'hFFFF_FFFF, "badsel_status", d);
    axi_read(5'h10, 32'h0, 32'h0, "badsel_count_raw", d);
    range_chk("badsel_count", d, 4, 6);
    axi_read(5'h08, 32'd120, 32'hFFFF_FFFF, "badsel_select_kept", d);

    // Overlapping AW/W/AR with responses back-pressured for 5 cycles.
    axi_write(5'h0C, 32'h1111_1111, 4'hF);
    sbq.push_back('{32'h1111_1111, 32'hFFFF_FFFF, "same_cycle_prewrite"});
    @(negedge clk);
    aw0 = aw_hs; ar0 = ar_hs;
    bready = 1'b0; rready = 1'b0;
    awaddr = 5'h0C; wdata = 32'h0000_0055; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h0C; arvalid = 1'b1;
    n = 0;
    while (!(bvalid && rvalid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("overlap_responses", {30'b0, bvalid, rvalid}, 32'h3, 32'hFFFF_FFFF);
    cap_r = rdata; cap_b = bresp; stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!bvalid || !rvalid || rdata !== cap_r || bresp !== cap_b) stable = 1'b0;
    end
    check("hold_stable", {31'b0, stable}, 32'h1, 32'hFFFF_FFFF);
    check("aw_accept_once", 32'(aw_hs - aw0), 32'd1, 32'hFFFF_FFFF);
    check("ar_accept_once", 32'(ar_hs - ar0), 32'd1, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    if (rvalid && rready) sb_pop_check(rdata, rresp);
    @(posedge clk); #1;
    axi_read(5'h0C, 32'h0000_0055, 32'hFFFF_FFFF, "overlap_write_landed", d);

    // Asynchronous reset in the middle of a burst and a measurement.
    axi_write(5'h08, 32'd5, 4'hF);
    base = done_pulses;
    axi_write(5'h00, 32'h1, 4'hF);
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    awaddr = 5'h0C; wdata = 32'h0000_0099; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 5'h0C; arvalid = 1'b1;
    n = 0;
    while (!(bvalid && rvalid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", {24'b0, awready, wready, bvalid, arready, rvalid, meas_done, bresp | rresp},
          32'h0, 32'hFFFF_FFFF);
    check("async_rst_rdata", rdata, 32'h0, 32'hFFFF_FFFF);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stable = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (bvalid || rvalid) stable = 1'b0;
    end
    check("no_resp_after_rst", {31'b0, stable}, 32'h1, 32'hFFFF_FFFF);
    check("meas_aborted", 32'(done_pulses - base), 32'd0, 32'hFFFF_FFFF);
    axi_read(5'h00, 32'h0, 32'hFFFF_FFFF, "rst_ctrl", d);
    axi_read(5'h0C, 32'h0, 32'hFFFF_FFFF, "rst_scratch", d);
    axi_read(5'h14, 32'h0, 32'hFFFF_FFFF, "rst_status", d);

    check("scoreboard_empty", 32'(sbq.size()), 32'd0, 32'hFFFF_FFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
